// File: rtl/alu_pkg.sv
// ============================================================================
//  Module : alu_pkg
//  Brief  : Opcode/function codes, shifter modes and immediate helpers for alu
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int unsigned c_DATA_W = 32;
   localparam int unsigned c_IMM_W  = 16;

   // I-type / branch opcodes (c_OP_RTYPE selects decode by function code)
   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_BLEZ  = 6'b000110;
   localparam logic [5:0] c_OP_BGTZ  = 6'b000111;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_ADDIU = 6'b001001;
   localparam logic [5:0] c_OP_SLTI  = 6'b001010;
   localparam logic [5:0] c_OP_SLTIU = 6'b001011;
   localparam logic [5:0] c_OP_ANDI  = 6'b001100;
   localparam logic [5:0] c_OP_ORI   = 6'b001101;
   localparam logic [5:0] c_OP_XORI  = 6'b001110;
   localparam logic [5:0] c_OP_LUI   = 6'b001111;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;

   localparam logic [5:0] c_FN_SLL  = 6'b000000;
   localparam logic [5:0] c_FN_SRL  = 6'b000010;
   localparam logic [5:0] c_FN_SRA  = 6'b000011;
   localparam logic [5:0] c_FN_SLLV = 6'b000100;
   localparam logic [5:0] c_FN_SRLV = 6'b000110;
   localparam logic [5:0] c_FN_SRAV = 6'b000111;
   localparam logic [5:0] c_FN_ADD  = 6'b100000;
   localparam logic [5:0] c_FN_ADDU = 6'b100001;
   localparam logic [5:0] c_FN_SUB  = 6'b100010;
   localparam logic [5:0] c_FN_SUBU = 6'b100011;
   localparam logic [5:0] c_FN_AND  = 6'b100100;
   localparam logic [5:0] c_FN_OR   = 6'b100101;
   localparam logic [5:0] c_FN_XOR  = 6'b100110;
   localparam logic [5:0] c_FN_NOR  = 6'b100111;
   localparam logic [5:0] c_FN_SLT  = 6'b101010;
   localparam logic [5:0] c_FN_SLTU = 6'b101011;

   typedef enum logic [1:0] {
      SHIFT_LL = 2'd0,
      SHIFT_RL = 2'd1,
      SHIFT_RA = 2'd2
   } shift_mode_e;

   function automatic logic [c_DATA_W-1:0] sext16(input logic [c_IMM_W-1:0] imm);
      return {{(c_DATA_W-c_IMM_W){imm[c_IMM_W-1]}}, imm};
   endfunction

   function automatic logic [c_DATA_W-1:0] zext16(input logic [c_IMM_W-1:0] imm);
      return {{(c_DATA_W-c_IMM_W){1'b0}}, imm};
   endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
//  Module : alu_shifter
//  Brief  : 32-bit logarithmic barrel shifter (left, logical right, arith right)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shifter
   import alu_pkg::*;
(
   input  logic [31:0]  value,
   input  logic [4:0]   amount,
   input  shift_mode_e  mode,
   output logic [31:0]  shifted
);

   logic [31:0] w_stage [0:5];
   logic        w_fill;

   assign w_fill     = (mode == SHIFT_RA) & value[31];
   assign w_stage[0] = value;

   // Stage i shifts by 2^i when amount[i] is set
   for (genvar i = 0; i < 5; i++) begin : g_stage
      localparam int c_N = 1 << i;
      assign w_stage[i+1] = !amount[i]         ? w_stage[i] :
                            (mode == SHIFT_LL) ? {w_stage[i][31-c_N:0], {c_N{1'b0}}} :
                                                 {{c_N{w_fill}}, w_stage[i][31:c_N]};
   end

   assign shifted = w_stage[5];

endmodule : alu_shifter

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
//  Module : alu
//  Brief  : MIPS-style execute-stage ALU with registered result and branch flag
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [4:0]  shamt,
   input  logic [5:0]  func,
   input  logic [15:0] raw_val,
   output logic [31:0] result,
   output logic        sig_b
);

   logic [31:0] w_sext;
   logic [31:0] w_zext;
   logic [31:0] w_sh_out;
   logic [4:0]  w_sh_amt;
   shift_mode_e w_sh_mode;
   logic [31:0] w_result;
   logic        w_sig_b;
   logic [31:0] r_result;
   logic        r_sig_b;

   assign w_sext = sext16(raw_val);
   assign w_zext = zext16(raw_val);

   // Variable shifts take their amount from rs; fixed shifts use shamt
   always_comb begin
      w_sh_mode = SHIFT_LL;
      w_sh_amt  = shamt;
      case (func)
         c_FN_SRL:  w_sh_mode = SHIFT_RL;
         c_FN_SRA:  w_sh_mode = SHIFT_RA;
         c_FN_SLLV: w_sh_amt  = rs_val[4:0];
         c_FN_SRLV: begin
            w_sh_mode = SHIFT_RL;
            w_sh_amt  = rs_val[4:0];
         end
         c_FN_SRAV: begin
            w_sh_mode = SHIFT_RA;
            w_sh_amt  = rs_val[4:0];
         end
         default: ;
      endcase
   end

   alu_shifter u_shifter (
      .value   (rt_val),
      .amount  (w_sh_amt),
      .mode    (w_sh_mode),
      .shifted (w_sh_out)
   );

   always_comb begin
      w_result = '0;
      w_sig_b  = 1'b0;
      case (opcode)
         c_OP_RTYPE: begin
            case (func)
               c_FN_ADD, c_FN_ADDU: w_result = rs_val + rt_val;
               c_FN_SUB, c_FN_SUBU: w_result = rs_val - rt_val;
               c_FN_AND:            w_result = rs_val & rt_val;
               c_FN_OR:             w_result = rs_val | rt_val;
               c_FN_XOR:            w_result = rs_val ^ rt_val;
               c_FN_NOR:            w_result = ~(rs_val | rt_val);
               c_FN_SLT:            w_result = {31'b0, $signed(rs_val) < $signed(rt_val)};
               c_FN_SLTU:           w_result = {31'b0, rs_val < rt_val};
               c_FN_SLL, c_FN_SRL, c_FN_SRA,
               c_FN_SLLV, c_FN_SRLV, c_FN_SRAV:
                                    w_result = w_sh_out;
               default:             w_result = '0;
            endcase
         end
         c_OP_ADDI, c_OP_ADDIU, c_OP_LW, c_OP_SW:
                     w_result = rs_val + w_sext;
         c_OP_SLTI:  w_result = {31'b0, $signed(rs_val) < $signed(w_sext)};
         c_OP_SLTIU: w_result = {31'b0, rs_val < w_sext};
         c_OP_ANDI:  w_result = rs_val & w_zext;
         c_OP_ORI:   w_result = rs_val | w_zext;
         c_OP_XORI:  w_result = rs_val ^ w_zext;
         c_OP_LUI:   w_result = {raw_val, 16'h0000};
         c_OP_BEQ: begin
            w_result = rs_val - rt_val;
            w_sig_b  = (rs_val == rt_val);
         end
         c_OP_BNE: begin
            w_result = rs_val - rt_val;
            w_sig_b  = (rs_val != rt_val);
         end
         c_OP_BLEZ: begin
            w_result = rs_val - rt_val;
            w_sig_b  = rs_val[31] | (rs_val == 32'h0);
         end
         c_OP_BGTZ: begin
            w_result = rs_val - rt_val;
            w_sig_b  = ~rs_val[31] & (rs_val != 32'h0);
         end
         default: begin
            w_result = '0;
            w_sig_b  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_sig_b  <= 1'b0;
      end else begin
         r_result <= w_result;
         r_sig_b  <= w_sig_b;
      end
   end

   assign result = r_result;
   assign sig_b  = r_sig_b;

endmodule : alu

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
//  Module : tb_alu
//  Brief  : Scoreboard testbench for alu with directed and random stimulus
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [4:0]  shamt;
   logic [5:0]  func;
   logic [15:0] raw_val;
   logic [31:0] result;
   logic        sig_b;

   typedef struct {
      logic [31:0] res;
      logic        b;
      string       name;
   } exp_t;

   exp_t q_exp[$];
   int   checks   = 0;
   int   failures = 0;

   alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .opcode  (opcode),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .shamt   (shamt),
      .func    (func),
      .raw_val (raw_val),
      .result  (result),
      .sig_b   (sig_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: returns {branch_taken, result}
   function automatic logic [32:0] ref_model(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [31:0] rs, input logic [31:0] rt,
                                             input logic [4:0] sa, input logic [15:0] imm);
      logic [31:0] se;
      logic [31:0] ze;
      logic [31:0] r;
      logic        b;
      se = {{16{imm[15]}}, imm};
      ze = {16'h0, imm};
      r  = 32'h0;
      b  = 1'b0;
      case (op)
         6'b000000: case (fn)
            6'b100000, 6'b100001: r = rs + rt;
            6'b100010, 6'b100011: r = rs - rt;
            6'b100100: r = rs & rt;
            6'b100101: r = rs | rt;
            6'b100110: r = rs ^ rt;
            6'b100111: r = ~(rs | rt);
            6'b101010: r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
            6'b101011: r = (rs < rt) ? 32'd1 : 32'd0;
            6'b000000: r = rt << sa;
            6'b000010: r = rt >> sa;
            6'b000011: r = $unsigned($signed(rt) >>> sa);
            6'b000100: r = rt << rs[4:0];
            6'b000110: r = rt >> rs[4:0];
            6'b000111: r = $unsigned($signed(rt) >>> rs[4:0]);
            default:   r = 32'h0;
         endcase
         6'b001000, 6'b001001, 6'b100011, 6'b101011: r = rs + se;
         6'b001010: r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
         6'b001011: r = (rs < se) ? 32'd1 : 32'd0;
         6'b001100: r = rs & ze;
         6'b001101: r = rs | ze;
         6'b001110: r = rs ^ ze;
         6'b001111: r = {imm, 16'h0};
         6'b000100: begin r = rs - rt; b = (rs == rt); end
         6'b000101: begin r = rs - rt; b = (rs != rt); end
         6'b000110: begin r = rs - rt; b = ($signed(rs) <= 0); end
         6'b000111: begin r = rs - rt; b = ($signed(rs) > 0); end
         default: ;
      endcase
      return {b, r};
   endfunction

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [31:0] er, input logic eb, input string nm);
      exp_t e;
      @(negedge clk);
      opcode  = op;
      func    = fn;
      rs_val  = rs;
      rt_val  = rt;
      shamt   = sa;
      raw_val = imm;
      e.res   = er;
      e.b     = eb;
      e.name  = nm;
      q_exp.push_back(e);
   endtask

   task automatic check(input string nm, input logic [31:0] act_r, input logic act_b,
                        input logic [31:0] er, input logic eb);
      checks++;
      if (act_r !== er || act_b !== eb) begin
         failures++;
         $display("FAIL %s: got result=%08h sig_b=%0b, expected result=%08h sig_b=%0b",
                  nm, act_r, act_b, er, eb);
      end
   endtask

   // Monitor: one registered result per clock for each issued operation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check(e.name, result, sig_b, e.res, e.b);
         end
      end
   end

   localparam logic [5:0] c_OPS [0:14] = '{6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                          6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
   localparam logic [5:0] c_FNS [0:15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                          6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

   initial begin
      logic [32:0] m;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  sa;
      logic [15:0] imm;
      int          wait_cnt;

      rst_n = 1'b0;
      opcode = 6'h0; func = 6'h0; rs_val = 32'h0; rt_val = 32'h0; shamt = 5'h0; raw_val = 16'h0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_state", result, sig_b, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(6'h00, 6'b100101, 32'd5,        32'd2,        5'd0, 16'h0,    32'd7,        1'b0, "or_5_2");
      issue(6'h00, 6'b100101, 32'h1F,       32'h1F,       5'd0, 16'h0,    32'h1F,       1'b0, "or_1f");
      issue(6'h00, 6'b100101, 32'd9,        32'hB,        5'd0, 16'h0,    32'hB,        1'b0, "or_9_b");
      issue(6'h00, 6'b100000, 32'h7FFFFFFF, 32'd1,        5'd0, 16'h0,    32'h80000000, 1'b0, "add_wrap");
      issue(6'h00, 6'b100010, 32'd3,        32'd5,        5'd0, 16'h0,    32'hFFFFFFFE, 1'b0, "sub_neg");
      issue(6'h00, 6'b101010, 32'hFFFFFFFF, 32'd1,        5'd0, 16'h0,    32'd1,        1'b0, "slt");
      issue(6'h00, 6'b101011, 32'hFFFFFFFF, 32'd1,        5'd0, 16'h0,    32'd0,        1'b0, "sltu");
      issue(6'b001000, 6'h0,  32'd10,       32'd0,        5'd0, 16'hFFFF, 32'd9,        1'b0, "addi_neg");
      issue(6'b001101, 6'h0,  32'd0,        32'd0,        5'd0, 16'h8001, 32'h00008001, 1'b0, "ori_zext");
      issue(6'b001111, 6'h0,  32'd0,        32'd0,        5'd0, 16'h1234, 32'h12340000, 1'b0, "lui");
      issue(6'h00, 6'b000011, 32'd0,        32'h80000000, 5'd4, 16'h0,    32'hF8000000, 1'b0, "sra");
      issue(6'h00, 6'b000010, 32'd0,        32'h80000000, 5'd4, 16'h0,    32'h08000000, 1'b0, "srl");
      issue(6'h00, 6'b000100, 32'd33,       32'd1,        5'd7, 16'h0,    32'd2,        1'b0, "sllv");
      issue(6'h00, 6'b000000, 32'd0,        32'hA5A5A5A5, 5'd0, 16'h0,    32'hA5A5A5A5, 1'b0, "sll_zero");
      issue(6'b000100, 6'h0,  32'd7,        32'd7,        5'd0, 16'h0,    32'd0,        1'b1, "beq");
      issue(6'b000101, 6'h0,  32'd7,        32'd7,        5'd0, 16'h0,    32'd0,        1'b0, "bne");
      issue(6'b000110, 6'h0,  32'd0,        32'd0,        5'd0, 16'h0,    32'd0,        1'b1, "blez");
      issue(6'b000111, 6'h0,  32'hFFFFFFFF, 32'd0,        5'd0, 16'h0,    32'hFFFFFFFF, 1'b0, "bgtz");
      issue(6'b111111, 6'h0,  32'd5,        32'd5,        5'd0, 16'h0,    32'd0,        1'b0, "bad_op");
      issue(6'h00, 6'b111111, 32'd5,        32'd5,        5'd0, 16'h0,    32'd0,        1'b0, "bad_func");

      for (int i = 0; i < 400; i++) begin
         op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : c_OPS[$urandom_range(0, 14)];
         fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : c_FNS[$urandom_range(0, 15)];
         rs  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         rt  = ($urandom_range(0, 5) == 0) ? rs : $urandom;
         sa  = 5'($urandom);
         imm = 16'($urandom);
         m   = ref_model(op, fn, rs, rt, sa, imm);
         issue(op, fn, rs, rt, sa, imm, m[31:0], m[32], "random");
      end

      wait_cnt = 0;
      while (q_exp.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      checks++;
      if (q_exp.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results outstanding, expected 0", q_exp.size());
      end

      // Asynchronous reset mid-cycle after a nonzero, branch-taken result
      issue(6'b000100, 6'h0, 32'd9, 32'd9, 5'd0, 16'h0, 32'd0, 1'b1, "pre_reset_beq");
      issue(6'h00, 6'b100101, 32'h10, 32'h01, 5'd0, 16'h0, 32'h11, 1'b0, "pre_reset_or");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", result, sig_b, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold", result, sig_b, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(6'h00, 6'b100001, 32'd40, 32'd2, 5'd0, 16'h0, 32'd42, 1'b0, "post_reset_addu");
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q_exp.size() != 0) begin
         failures++;
         $display("FAIL final_drain: %0d results outstanding, expected 0", q_exp.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu

`default_nettype wire
